alu_scheduler: RTL and testbench

Round-robin scheduler that shares one combinational `ALU` instance between `NREQ` requesters. It accepts one operation at a time over a valid/ready handshake, drives the registered operands and opcode into the ALU, and holds them for `ALU_LAT` cycles. It then captures `out`/`zero`/`error` and returns them to the winning requester, tagged with its index, over a valid/ready response channel. It sits between the EAMTA_DDA requesters and the ALU; the ALU is instantiated outside this block.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_scheduler_if.sv | 34 +++
 rtl/alu_scheduler_rr_arbiter.sv | 43 ++++
 rtl/alu_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_alu_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler slice.
//   - Opcode constants understood by the shared ALU.
//   - Scheduler FSM state type.
//   - op_is_legal(): true for opcodes the ALU implements.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } sched_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request/response bus between NREQ requesters and the ALU scheduler.
//   master : requester side (drives req_*, resp_ready)
//   slave  : scheduler side (drives req_ready, resp_*)
// Field i of req_op / req_in1 / req_in2 belongs to requester i.
interface alu_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_in1;
  logic [WIDTH*NREQ-1:0] req_in2;
  logic [NREQ-1:0]       req_invalid;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [2*WIDTH-1:0]    resp_out;
  logic                  resp_zero;
  logic                  resp_error;

  modport master (
    output req_valid, req_op, req_in1, req_in2, req_invalid, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_out, resp_zero, resp_error
  );

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, req_invalid, resp_ready,
    output req_ready, resp_valid, resp_id, resp_out, resp_zero, resp_error
  );
endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : index with highest priority this cycle (must be < N)
//   gnt     : one-hot grant, zero when no request
//   gnt_idx : encoded index of the granted requester
// The search starts at ptr and walks upward with wrap-around.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found_s;
  logic [IW:0]   pos_s;

  // First asserted request at or after ptr, modulo N.
  always_comb begin
    gnt     = {N{1'b0}};
    gnt_idx = {IW{1'b0}};
    found_s = 1'b0;
    pos_s   = {(IW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      pos_s = {1'b0, ptr} + (IW+1)'(k);
      if (pos_s >= (IW+1)'(N)) begin
        pos_s = pos_s - (IW+1)'(N);
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && req[pos_s[IW-1:0]]) begin
        gnt[pos_s[IW-1:0]] = 1'b1;
        gnt_idx            = pos_s[IW-1:0];
        found_s            = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one external combinational ALU between NREQ
// requesters, one operation in flight at a time.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : request channels and tagged response channel
//   alu_in1/in2/op/invalid : registered drive to the ALU, held outside EXEC
//   alu_out/zero/error: ALU results, sampled in CAPT
//   busy              : high whenever the FSM is not idle
// Optional feature macro: ALU_SCHED_DIVZERO_BYPASS_EN -- divides by zero or
// with the invalid flag set are answered directly (error, all-ones result)
// without visiting the ALU.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int NREQ    = 4,
  parameter  int ALU_LAT = 1,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_scheduler_if.slave     bus,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  output logic [3:0]         alu_op,
  output logic               alu_invalid,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_zero,
  input  logic               alu_error,
  output logic               busy
);

  sched_state_t       state_r, state_nxt_s;
  logic [3:0]         lat_cnt_r;
  logic [IDW-1:0]     rr_ptr_r, id_r;
  logic [WIDTH-1:0]   alu_in1_r, alu_in2_r;
  logic [3:0]         alu_op_r;
  logic               alu_invalid_r;
  logic [2*WIDTH-1:0] resp_out_r;
  logic               resp_zero_r, resp_error_r;

  logic [NREQ-1:0]    gnt_s, req_ready_s;
  logic [IDW-1:0]     gnt_idx_s;
  logic [3:0]         sel_op_s;
  logic [WIDTH-1:0]   sel_in1_s, sel_in2_s;
  logic               sel_inv_s;
  logic               bypass_s;
  logic               accept_s, to_exec_s, capt_s, resp_done_s;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign sel_op_s  = bus.req_op[gnt_idx_s*4 +: 4];
  assign sel_in1_s = bus.req_in1[gnt_idx_s*WIDTH +: WIDTH];
  assign sel_in2_s = bus.req_in2[gnt_idx_s*WIDTH +: WIDTH];
  assign sel_inv_s = bus.req_invalid[gnt_idx_s];

`ifdef ALU_SCHED_DIVZERO_BYPASS_EN
  assign bypass_s = (sel_op_s == OP_DIV) &&
                    ((sel_in2_s == {WIDTH{1'b0}}) || sel_inv_s);
`else
  assign bypass_s = 1'b0;
`endif

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    req_ready_s = {NREQ{1'b0}};
    accept_s    = 1'b0;
    to_exec_s   = 1'b0;
    capt_s      = 1'b0;
    resp_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          req_ready_s = gnt_s;
          accept_s    = 1'b1;
          if (op_is_legal(sel_op_s) && !bypass_s) begin
            to_exec_s   = 1'b1;
            state_nxt_s = ST_EXEC;
          end else begin
            // Illegal or bypassed ops are answered without the ALU.
            state_nxt_s = ST_RESP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (lat_cnt_r == 4'd0) begin
          state_nxt_s = ST_CAPT;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_CAPT: begin
        capt_s      = 1'b1;
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          resp_done_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: ALU drive, latency counter, response payload and pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_r     <= 4'd0;
      rr_ptr_r      <= {IDW{1'b0}};
      id_r          <= {IDW{1'b0}};
      alu_in1_r     <= {WIDTH{1'b0}};
      alu_in2_r     <= {WIDTH{1'b0}};
      alu_op_r      <= 4'd0;
      alu_invalid_r <= 1'b0;
      resp_out_r    <= {(2*WIDTH){1'b0}};
      resp_zero_r   <= 1'b0;
      resp_error_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        id_r <= gnt_idx_s;
      end
      if (to_exec_s) begin
        // Only legal, non-bypassed ops ever reach the ALU drive.
        alu_in1_r     <= sel_in1_s;
        alu_in2_r     <= sel_in2_s;
        alu_op_r      <= sel_op_s;
        alu_invalid_r <= sel_inv_s;
        lat_cnt_r     <= 4'(ALU_LAT - 1);
      end else if ((state_r == ST_EXEC) && (lat_cnt_r != 4'd0)) begin
        lat_cnt_r <= lat_cnt_r - 4'd1;
      end
      if (accept_s && !to_exec_s) begin
        resp_out_r   <= bypass_s ? {(2*WIDTH){1'b1}} : {(2*WIDTH){1'b0}};
        resp_zero_r  <= 1'b0;
        resp_error_r <= 1'b1;
      end else if (capt_s) begin
        resp_out_r   <= alu_out;
        resp_zero_r  <= alu_zero;
        resp_error_r <= alu_error;
      end
      if (resp_done_s) begin
        rr_ptr_r <= (id_r == IDW'(NREQ - 1)) ? {IDW{1'b0}} : id_r + {{(IDW-1){1'b0}}, 1'b1};
      end
    end
  end

  // req_ready is forced low during reset so every output reads 0 at once.
  assign bus.req_ready  = rst_n ? req_ready_s : {NREQ{1'b0}};
  assign bus.resp_valid = (state_r == ST_RESP);
  assign bus.resp_id    = id_r;
  assign bus.resp_out   = resp_out_r;
  assign bus.resp_zero  = resp_zero_r;
  assign bus.resp_error = resp_error_r;
  assign alu_in1        = alu_in1_r;
  assign alu_in2        = alu_in2_r;
  assign alu_op         = alu_op_r;
  assign alu_invalid    = alu_invalid_r;
  assign busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
module tb_alu_scheduler;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int LAT = 1;

  logic clk;
  logic rst_n;
  logic [W-1:0]   alu_in1, alu_in2;
  logic [3:0]     alu_op;
  logic           alu_invalid;
  logic [2*W-1:0] alu_out;
  logic           alu_zero, alu_error;
  logic           busy;

  alu_scheduler_if #(.WIDTH(W), .NREQ(N)) bus ();

  alu_scheduler #(.WIDTH(W), .NREQ(N), .ALU_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_op      (alu_op),
    .alu_invalid (alu_invalid),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .alu_error   (alu_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int alu_op_bad = 0;

  // Behavioural model of the external ALU: {out, zero, error}.
  function automatic logic [2*W+1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op, input logic inv);
    logic [2*W-1:0] r;
    logic e;
    r = '0;
    e = 1'b0;
    case (op)
      4'd0: r = (2*W)'(a) + (2*W)'(b);
      4'd1: r = (2*W)'(a) - (2*W)'(b);
      4'd2: r = (2*W)'(a) * (2*W)'(b);
      4'd3: if (b == '0) e = 1'b1; else r = (2*W)'(a / b);
      default: e = 1'b1;
    endcase
    if (inv) begin
      e = 1'b1;
      r = '0;
    end
    return {r, (!e && (r == '0)), e};
  endfunction

  always_comb {alu_out, alu_zero, alu_error} = alu_ref(alu_in1, alu_in2, alu_op, alu_invalid);

  always @(negedge clk) if (alu_op > 4'd3) alu_op_bad++;

  function automatic logic is_direct(input logic [3:0] op, input logic [W-1:0] b, input logic inv);
    if (op > 4'd3) return 1'b1;
`ifdef ALU_SCHED_DIVZERO_BYPASS_EN
    if (op == 4'd3 && (b == '0 || inv)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Expected response payload {out, zero, error} at scheduler level.
  function automatic logic [2*W+1:0] expect_resp(input logic [3:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b, input logic inv);
    if (op > 4'd3) return {{(2*W){1'b0}}, 1'b0, 1'b1};
    if (is_direct(op, b, inv)) return {{(2*W){1'b1}}, 1'b0, 1'b1};
    return alu_ref(a, b, op, inv);
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int idx;
    int cnt;
    idx = -1;
    cnt = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin idx = i; cnt++; end
    if (cnt > 1) idx = -2;
    return idx;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic inv);
    bus.req_op[4*id +: 4]  = op;
    bus.req_in1[W*id +: W] = a;
    bus.req_in2[W*id +: W] = b;
    bus.req_invalid[id]    = inv;
  endtask

  // Polls (from a negedge) until req_ready is non-zero, bounded.
  task automatic wait_grant(output int g);
    g = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        g = oh_idx(bus.req_ready);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  // One isolated request; returns grant index and cycles from accept to resp_valid.
  task automatic txn(input int id, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic inv, output int g, output int lat);
    logic seen;
    @(negedge clk);
    set_req(id, op, a, b, inv);
    bus.req_valid     = '0;
    bus.req_valid[id] = 1'b1;
    wait_grant(g);
    @(negedge clk);
    bus.req_valid = '0;
    lat  = 1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!seen) lat = -1;
  endtask

  typedef struct {
    int             id;
    logic [3:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           inv;
    logic [2*W-1:0] eout;
    logic           ez;
    logic           ee;
    int             elat;
  } vec_t;

  vec_t vecs[11];

  // Random-phase model state.
  logic           pending [N];
  logic [3:0]     p_op    [N];
  logic [W-1:0]   p_a     [N];
  logic [W-1:0]   p_b     [N];
  logic           p_inv   [N];
  logic           inflight;
  logic           first_seen;
  logic [2*W+1:0] exp_resp;
  logic [1:0]     exp_id;
  int             exp_lat;
  int             issue_cyc;
  int             model_ptr;
  int             resp_count;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int g, lat, exp_g, act_g, r;
    logic any_p, saw;

    vecs[0]  = '{2, 4'd0, 8'd10,  8'd20,  1'b0, 16'd30,     1'b0, 1'b0, 3};
    vecs[1]  = '{1, 4'd1, 8'd5,   8'd5,   1'b0, 16'd0,      1'b1, 1'b0, 3};
    vecs[2]  = '{0, 4'd2, 8'd200, 8'd3,   1'b0, 16'd600,    1'b0, 1'b0, 3};
    vecs[3]  = '{3, 4'd3, 8'd100, 8'd7,   1'b0, 16'd14,     1'b0, 1'b0, 3};
    vecs[4]  = '{0, 4'd7, 8'd1,   8'd2,   1'b0, 16'd0,      1'b0, 1'b1, 1};
    vecs[5]  = '{2, 4'd15, 8'd0,  8'd0,   1'b0, 16'd0,      1'b0, 1'b1, 1};
`ifdef ALU_SCHED_DIVZERO_BYPASS_EN
    vecs[6]  = '{1, 4'd3, 8'd9,   8'd0,   1'b0, 16'hFFFF,   1'b0, 1'b1, 1};
    vecs[7]  = '{3, 4'd3, 8'd8,   8'd2,   1'b1, 16'hFFFF,   1'b0, 1'b1, 1};
`else
    vecs[6]  = '{1, 4'd3, 8'd9,   8'd0,   1'b0, 16'd0,      1'b0, 1'b1, 3};
    vecs[7]  = '{3, 4'd3, 8'd8,   8'd2,   1'b1, 16'd0,      1'b0, 1'b1, 3};
`endif
    vecs[8]  = '{2, 4'd0, 8'd10,  8'd20,  1'b1, 16'd0,      1'b0, 1'b1, 3};
    vecs[9]  = '{1, 4'd1, 8'd3,   8'd5,   1'b0, 16'hFFFE,   1'b0, 1'b0, 3};
    vecs[10] = '{0, 4'd2, 8'd255, 8'd255, 1'b0, 16'hFE01,   1'b0, 1'b0, 3};

    bus.req_valid   = '0;
    bus.req_op      = '0;
    bus.req_in1     = '0;
    bus.req_in2     = '0;
    bus.req_invalid = '0;
    bus.resp_ready  = 1'b1;
    rst_n = 1'b0;
    #12;
    check("reset_outputs",
          {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_zero,
           bus.resp_error, alu_in1, alu_in2, alu_op, alu_invalid, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness: all requesters hold valid.
    for (int i = 0; i < N; i++) set_req(i, 4'd0, 8'(i + 1), 8'd1, 1'b0);
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check($sformatf("rr_grant_%0d", k), 64'(g), 64'(k % N));
      @(negedge clk);
    end
    bus.req_valid = '0;
    wait_idle("rr_drain");

    // Table-driven isolated transactions.
    for (int v = 0; v < 11; v++) begin
      txn(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].inv, g, lat);
      check($sformatf("vec%0d_grant", v), 64'(g), 64'(vecs[v].id));
      check($sformatf("vec%0d_latency", v), 64'(lat), 64'(vecs[v].elat));
      check($sformatf("vec%0d_id", v), 64'(bus.resp_id), 64'(vecs[v].id));
      check($sformatf("vec%0d_payload", v), {bus.resp_out, bus.resp_zero, bus.resp_error},
            {vecs[v].eout, vecs[v].ez, vecs[v].ee});
    end

    // Response backpressure.
    @(negedge clk);
    bus.resp_ready = 1'b0;
    txn(1, 4'd0, 8'd3, 8'd4, 1'b0, g, lat);
    set_req(0, 4'd0, 8'd1, 8'd1, 1'b0);
    bus.req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_%0d", i), {bus.resp_valid, bus.req_ready, bus.resp_id, bus.resp_out},
            {1'b1, 4'b0000, 2'd1, 16'd7});
      if (i < 4) begin
        @(negedge clk);
        #1;
      end
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release", {bus.resp_valid, busy, bus.req_ready}, {1'b0, 1'b0, 4'b0001});
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    check("drop_no_accept", 64'(busy), 64'd0);
    set_req(3, 4'd0, 8'd2, 8'd2, 1'b0);
    bus.req_valid[0] = 1'b1;
    bus.req_valid[3] = 1'b1;
    wait_grant(g);
    check("ptr_after_drop", 64'(g), 64'd3);
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle("bp_drain");

    // Clean restart so the model pointer starts at 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the scheduler-level model.
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    inflight = 1'b0;
    first_seen = 1'b0;
    model_ptr = 0;
    resp_count = 0;
    exp_resp = '0;
    exp_id = '0;
    exp_lat = 0;
    issue_cyc = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clk);
      if (cyc < 700) begin
        for (int i = 0; i < N; i++) begin
          if (!pending[i] && $urandom_range(0, 3) == 0) begin
            r = int'($urandom_range(0, 9));
            p_op[i]  = (r < 8) ? 4'(r % 4) : 4'($urandom_range(4, 15));
            p_a[i]   = 8'($urandom_range(0, 255));
            p_b[i]   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            p_inv[i] = ($urandom_range(0, 7) == 0);
            pending[i] = 1'b1;
            set_req(i, p_op[i], p_a[i], p_b[i], p_inv[i]);
          end
        end
      end
      for (int i = 0; i < N; i++) bus.req_valid[i] = pending[i];
      bus.resp_ready = ($urandom_range(0, 2) != 0);
      #1;
      any_p = 1'b0;
      for (int i = 0; i < N; i++) any_p = any_p | pending[i];
      exp_g = -1;
      if (!inflight && any_p) begin
        for (int k = 0; k < N; k++) begin
          if (exp_g < 0 && pending[(model_ptr + k) % N]) exp_g = (model_ptr + k) % N;
        end
      end
      act_g = (bus.req_ready == '0) ? -1 : oh_idx(bus.req_ready);
      if (exp_g >= 0 || bus.req_ready != '0) check("rnd_grant", 64'(act_g), 64'(exp_g));
      if (exp_g >= 0) begin
        inflight   = 1'b1;
        first_seen = 1'b0;
        exp_id     = 2'(exp_g);
        exp_resp   = expect_resp(p_op[exp_g], p_a[exp_g], p_b[exp_g], p_inv[exp_g]);
        exp_lat    = is_direct(p_op[exp_g], p_b[exp_g], p_inv[exp_g]) ? 1 : LAT + 2;
        issue_cyc  = cyc;
        pending[exp_g] = 1'b0;
      end else if (bus.resp_valid) begin
        check("rnd_resp_expected", 64'(inflight), 64'd1);
        if (!first_seen) begin
          check("rnd_latency", 64'(cyc - issue_cyc), 64'(exp_lat));
          first_seen = 1'b1;
        end
        check("rnd_resp", {bus.resp_id, bus.resp_out, bus.resp_zero, bus.resp_error},
              {exp_id, exp_resp});
        if (bus.resp_ready) begin
          model_ptr = (int'(exp_id) + 1) % N;
          inflight  = 1'b0;
          resp_count++;
        end
      end
      if (cyc >= 700 && !inflight && !any_p && exp_g < 0) break;
    end
    any_p = 1'b0;
    for (int i = 0; i < N; i++) any_p = any_p | pending[i];
    check("rnd_drained", {inflight, any_p}, 64'd0);
    check("rnd_enough_responses", 64'(resp_count >= 50), 64'd1);
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    wait_idle("rnd_idle");

    // Reset during EXEC after moving the pointer away from 0.
    txn(0, 4'd0, 8'd1, 8'd1, 1'b0, g, lat);
    @(negedge clk);
    set_req(2, 4'd0, 8'd5, 8'd6, 1'b1);
    bus.req_valid[2] = 1'b1;
    wait_grant(g);
    check("rst_pre_grant", 64'(g), 64'd2);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("rst_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          {bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_out, bus.resp_zero,
           bus.resp_error, alu_in1, alu_in2, alu_op, alu_invalid, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.resp_valid || busy) saw = 1'b1;
      @(negedge clk);
    end
    check("rst_no_response", 64'(saw), 64'd0);
    set_req(0, 4'd0, 8'd1, 8'd2, 1'b0);
    set_req(3, 4'd0, 8'd3, 8'd4, 1'b0);
    bus.req_valid[0] = 1'b1;
    bus.req_valid[3] = 1'b1;
    wait_grant(g);
    check("rst_ptr_zero", 64'(g), 64'd0);
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle("final_idle");

    check("alu_op_never_illegal", 64'(alu_op_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
